reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter ENTRIES, 3, number of station entries (1..8).
REQ-002 SHALL have parameter TAG_BASE, 1, tag of entry 0; entry i tag = TAG_BASE+i; tag 0 = "value ready".
REQ-003 SHALL have parameter TAG_W, 4, tag width.
REQ-004 SHALL have parameter DATA_W, 32, operand width.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 en  input  1  issue request (this station's ResStationEN bit from the control unit).
REQ-008 ALUop  input  2  operation code, stored and forwarded unchanged.
REQ-009 vj / vk  input  DATA_W  operand values, valid when the matching qj/qk = 0.
REQ-010 qj / qk  input  TAG_W  producer tags of the operands; 0 = ready.
REQ-011 isFull  output  1  all entries non-FREE.
REQ-012 issue_tag  output  TAG_W  tag the entry allocated by the current issue will receive; 0 when isFull.
REQ-013 cdb_valid / cdb_tag / cdb_data  input  1 / TAG_W / DATA_W  common data bus broadcast.
REQ-014 exec_valid  output  1  dispatch request to the functional unit.
REQ-015 exec_ready  input  1  functional unit accepts the dispatch.
REQ-016 exec_op / exec_a / exec_b / exec_tag  output  2 / DATA_W / DATA_W / TAG_W  dispatched op, Vj, Vk, tag.

Function
REQ-017 Each entry SHALL hold busy state, op, Vj, Qj, Vk, Qk, and one of the states FREE, WAIT, READY, DISP, EXEC.
REQ-018 isFull SHALL be combinational from current state only; issue_tag SHALL be the tag of the lowest-indexed FREE entry.
REQ-019 On en=1 and isFull=0, the lowest FREE entry SHALL be written at the edge and go to READY if both Q are 0 after bypass, else to WAIT.
REQ-020 en=1 while isFull=1 SHALL be ignored with no state change.
REQ-021 Issue bypass: if cdb_valid and cdb_tag equals a nonzero incoming qj/qk, SHALL store cdb_data and Q=0.
REQ-022 Each WAIT entry whose Qj/Qk equals cdb_tag while cdb_valid=1 SHALL capture cdb_data and clear that Q; it goes to READY at the edge at which its last Q clears.
REQ-023 When no dispatch is pending, or one completes this cycle, one READY entry SHALL be selected per the REQ-033/034 policy, latched into the exec_* registers, and moved to DISP; exec_valid SHALL rise the cycle after the entry becomes READY.
REQ-024 exec_* outputs SHALL stay stable while exec_valid=1 and exec_ready=0.
REQ-025 When exec_valid=1 and exec_ready=1, the entry SHALL go DISP->EXEC. Back-to-back dispatch SHALL be allowed in the same edge.
REQ-026 An EXEC entry SHALL return to FREE at the edge where cdb_valid=1 and cdb_tag equals its tag. The freed slot SHALL be visible to isFull only from the next cycle.
REQ-027 A CDB tag matching no entry, or tag 0, SHALL have no effect.
REQ-028 One CDB broadcast SHALL be able to wake multiple entries and free one entry in the same cycle.

Reset
REQ-029 rst=1 SHALL, at the edge, force every entry to FREE and clear all Q fields.
REQ-030 Reset values: exec_valid=0, exec_op=0, exec_a=0, exec_b=0, exec_tag=0, isFull=0, issue_tag=TAG_BASE.
REQ-031 rst asserted mid-dispatch SHALL drop the pending dispatch without an exec_valid/exec_ready handshake.
REQ-032 rst SHALL take priority over en and cdb_valid in the same cycle.

Configuration
REQ-033 With macro RS_AGE_PRIORITY_EN defined, selection SHALL pick the oldest READY entry by issue order, tracked with an ENTRIES x ENTRIES age matrix updated on issue.
REQ-034 Without RS_AGE_PRIORITY_EN, selection SHALL pick the lowest-indexed READY entry and no age state SHALL be synthesized.

Verification
REQ-035 Reset, then issue add with qj=0, qk=0, vj=5, vk=7, exec_ready=1 -> exec_valid=1 one cycle after the entry goes READY, exec_a=5, exec_b=7, exec_tag=1.
REQ-036 Issue with qj=2; three cycles later CDB tag 2, data 0x10 -> entry READY next edge; exec_a=0x10.
REQ-037 Issue with qk=3 in the same cycle as CDB tag 3, data 9 -> bypass; exec_b=9 with no wait.
REQ-038 Fill 3 entries -> isFull=1, a 4th en is ignored; CDB broadcast of tag 1 after its dispatch -> isFull=0 next cycle, issue_tag=1.
REQ-039 Hold exec_ready=0 for 4 cycles with two READY entries -> exec_* unchanged; entry 2 issued before entry 1 is dispatched first only with RS_AGE_PRIORITY_EN.
REQ-040 Assert rst while exec_valid=1 -> next cycle exec_valid=0, isFull=0, all entries FREE.

Source files
------------

// File: rtl/reservation_station_if.sv
// reservation_station_if: issue, common-data-bus and dispatch signals of one
// reservation station. The master side is the control unit / functional unit
// environment; the slave side is the station itself.
interface reservation_station_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic              en;
  logic [1:0]        ALUop;
  logic [DATA_W-1:0] vj;
  logic [DATA_W-1:0] vk;
  logic [TAG_W-1:0]  qj;
  logic [TAG_W-1:0]  qk;
  logic              isFull;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              exec_valid;
  logic              exec_ready;
  logic [1:0]        exec_op;
  logic [DATA_W-1:0] exec_a;
  logic [DATA_W-1:0] exec_b;
  logic [TAG_W-1:0]  exec_tag;

  modport master (
    output en, ALUop, vj, vk, qj, qk, cdb_valid, cdb_tag, cdb_data, exec_ready,
    input  isFull, issue_tag, exec_valid, exec_op, exec_a, exec_b, exec_tag
  );

  modport slave (
    input  en, ALUop, vj, vk, qj, qk, cdb_valid, cdb_tag, cdb_data, exec_ready,
    output isFull, issue_tag, exec_valid, exec_op, exec_a, exec_b, exec_tag
  );
endinterface

// File: rtl/reservation_station.sv
// reservation_station: ENTRIES-deep Tomasulo reservation station with CDB
// wakeup, issue-time CDB bypass and one registered dispatch port.
// Build option: define RS_AGE_PRIORITY_EN to dispatch the oldest READY entry
// (tracked by an age matrix) instead of the lowest-indexed READY entry.
//
// Entry state | meaning
//   FREE      | slot empty, available for issue
//   WAIT      | issued, at least one operand tag still outstanding
//   READY     | both operands present, eligible for dispatch
//   DISP      | latched into exec_* registers, waiting for exec_ready
//   EXEC      | accepted by the functional unit, waiting for its CDB result
module reservation_station #(
  parameter int ENTRIES  = 3,
  parameter int TAG_BASE = 1,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32
) (
  input logic                  clk,
  input logic                  rst,
  reservation_station_if.slave bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [2:0] {S_FREE, S_WAIT, S_READY, S_DISP, S_EXEC} ent_state_t;

  ent_state_t        st_q [ENTRIES];
  ent_state_t        st_d [ENTRIES];
  logic [1:0]        op_q [ENTRIES];
  logic [1:0]        op_d [ENTRIES];
  logic [DATA_W-1:0] vj_q [ENTRIES];
  logic [DATA_W-1:0] vj_d [ENTRIES];
  logic [DATA_W-1:0] vk_q [ENTRIES];
  logic [DATA_W-1:0] vk_d [ENTRIES];
  logic [TAG_W-1:0]  qj_q [ENTRIES];
  logic [TAG_W-1:0]  qj_d [ENTRIES];
  logic [TAG_W-1:0]  qk_q [ENTRIES];
  logic [TAG_W-1:0]  qk_d [ENTRIES];

  logic              exec_valid_q, exec_valid_d;
  logic [1:0]        exec_op_q, exec_op_d;
  logic [DATA_W-1:0] exec_a_q, exec_a_d;
  logic [DATA_W-1:0] exec_b_q, exec_b_d;
  logic [TAG_W-1:0]  exec_tag_q, exec_tag_d;

  logic              is_full;
  logic [IDX_W-1:0]  free_idx;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              do_issue;

  function automatic logic [TAG_W-1:0] tag_of(input logic [IDX_W-1:0] idx);
    return TAG_W'(TAG_BASE) + TAG_W'(idx);
  endfunction

  // Tag 0 means "value present", so it never matches a broadcast.
  function automatic logic cdb_hit(input logic v, input logic [TAG_W-1:0] t,
                                   input logic [TAG_W-1:0] q);
    return v && (q != '0) && (q == t);
  endfunction

  // Lowest FREE slot; the station is full when there is none.
  always_comb begin
    is_full  = 1'b1;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (st_q[i] == S_FREE) begin
        is_full  = 1'b0;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign do_issue = bus.en && !is_full;

`ifdef RS_AGE_PRIORITY_EN
  // older[i][j] is set when entry i was issued before entry j.
  logic [ENTRIES-1:0] older [ENTRIES];

  // Pick the READY entry that is older than every other READY entry.
  always_comb begin
    logic oldest;
    oldest    = 1'b0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      oldest = (st_q[i] == S_READY);
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && st_q[j] == S_READY && !older[i][j]) oldest = 1'b0;
      end
      if (oldest && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // A newly issued entry becomes younger than every other slot; stale bits of
  // FREE slots are harmless because they are rewritten on their next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) older[i] <= '0;
    end else if (do_issue) begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (IDX_W'(i) == free_idx)      older[i][j] <= 1'b0;
          else if (IDX_W'(j) == free_idx) older[i][j] <= 1'b1;
        end
      end
    end
  end
`else
  // Pick the lowest-indexed READY entry.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (st_q[i] == S_READY) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // Next state: CDB wakeup/free, dispatch handshake and selection, then issue.
  always_comb begin
    st_d         = st_q;
    op_d         = op_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    exec_valid_d = exec_valid_q;
    exec_op_d    = exec_op_q;
    exec_a_d     = exec_a_q;
    exec_b_d     = exec_b_q;
    exec_tag_d   = exec_tag_q;

    for (int i = 0; i < ENTRIES; i++) begin
      case (st_q[i])
        S_WAIT: begin
          if (cdb_hit(bus.cdb_valid, bus.cdb_tag, qj_q[i])) begin
            vj_d[i] = bus.cdb_data;
            qj_d[i] = '0;
          end
          if (cdb_hit(bus.cdb_valid, bus.cdb_tag, qk_q[i])) begin
            vk_d[i] = bus.cdb_data;
            qk_d[i] = '0;
          end
          if (qj_d[i] == '0 && qk_d[i] == '0) st_d[i] = S_READY;
        end
        S_DISP: if (exec_valid_q && bus.exec_ready) st_d[i] = S_EXEC;
        S_EXEC: if (cdb_hit(bus.cdb_valid, bus.cdb_tag, tag_of(IDX_W'(i)))) st_d[i] = S_FREE;
        default: ;
      endcase
    end

    // The dispatch register refills in the same edge that it is accepted.
    if (!exec_valid_q || bus.exec_ready) begin
      exec_valid_d = sel_found;
      if (sel_found) begin
        st_d[sel_idx] = S_DISP;
        exec_op_d     = op_q[sel_idx];
        exec_a_d      = vj_q[sel_idx];
        exec_b_d      = vk_q[sel_idx];
        exec_tag_d    = tag_of(sel_idx);
      end
    end

    if (do_issue) begin
      op_d[free_idx] = bus.ALUop;
      vj_d[free_idx] = bus.vj;
      vk_d[free_idx] = bus.vk;
      qj_d[free_idx] = bus.qj;
      qk_d[free_idx] = bus.qk;
      if (cdb_hit(bus.cdb_valid, bus.cdb_tag, bus.qj)) begin
        vj_d[free_idx] = bus.cdb_data;
        qj_d[free_idx] = '0;
      end
      if (cdb_hit(bus.cdb_valid, bus.cdb_tag, bus.qk)) begin
        vk_d[free_idx] = bus.cdb_data;
        qk_d[free_idx] = '0;
      end
      st_d[free_idx] = (qj_d[free_idx] == '0 && qk_d[free_idx] == '0) ? S_READY : S_WAIT;
    end
  end

  // State register; reset drops any pending dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        st_q[i] <= S_FREE;
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
      exec_valid_q <= 1'b0;
      exec_op_q    <= '0;
      exec_a_q     <= '0;
      exec_b_q     <= '0;
      exec_tag_q   <= '0;
    end else begin
      st_q         <= st_d;
      op_q         <= op_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      exec_valid_q <= exec_valid_d;
      exec_op_q    <= exec_op_d;
      exec_a_q     <= exec_a_d;
      exec_b_q     <= exec_b_d;
      exec_tag_q   <= exec_tag_d;
    end
  end

  assign bus.isFull     = is_full;
  assign bus.issue_tag  = is_full ? '0 : tag_of(free_idx);
  assign bus.exec_valid = exec_valid_q;
  assign bus.exec_op    = exec_op_q;
  assign bus.exec_a     = exec_a_q;
  assign bus.exec_b     = exec_b_q;
  assign bus.exec_tag   = exec_tag_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the station.
module tb_reservation_station;
  localparam int ENT      = 3;
  localparam int TAG_BASE = 1;

  localparam int M_FREE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_READY = 2;
  localparam int M_DISP  = 3;
  localparam int M_EXEC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  reservation_station_if #(.TAG_W(4), .DATA_W(32)) bus ();

  reservation_station #(.ENTRIES(ENT), .TAG_BASE(TAG_BASE), .TAG_W(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: per-slot records plus an issue-order list.
  int          m_st [ENT];
  logic [1:0]  m_op [ENT];
  logic [31:0] m_vj [ENT];
  logic [31:0] m_vk [ENT];
  logic [3:0]  m_qj [ENT];
  logic [3:0]  m_qk [ENT];
  bit          m_ev;
  logic [1:0]  m_eop;
  logic [31:0] m_ea, m_eb;
  logic [3:0]  m_etag;
  int          order [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_free();
    for (int i = 0; i < ENT; i++) if (m_st[i] == M_FREE) return i;
    return -1;
  endfunction

  function automatic int model_pick();
`ifdef RS_AGE_PRIORITY_EN
    foreach (order[k]) if (m_st[order[k]] == M_READY) return order[k];
`else
    for (int i = 0; i < ENT; i++) if (m_st[i] == M_READY) return i;
`endif
    return -1;
  endfunction

  function automatic bit hit(input logic [3:0] q);
    return bus.cdb_valid && q != 0 && q == bus.cdb_tag;
  endfunction

  task automatic model_step();
    int nst [ENT];
    logic [31:0] nvj [ENT];
    logic [31:0] nvk [ENT];
    logic [3:0]  nqj [ENT];
    logic [3:0]  nqk [ENT];
    int fi, sel;
    if (rst) begin
      for (int i = 0; i < ENT; i++) begin
        m_st[i] = M_FREE; m_qj[i] = 0; m_qk[i] = 0;
      end
      m_ev = 0; m_eop = 0; m_ea = 0; m_eb = 0; m_etag = 0;
      order.delete();
      return;
    end
    fi = model_free();
    nst = m_st; nvj = m_vj; nvk = m_vk; nqj = m_qj; nqk = m_qk;
    for (int i = 0; i < ENT; i++) begin
      if (m_st[i] == M_WAIT) begin
        if (hit(m_qj[i])) begin nvj[i] = bus.cdb_data; nqj[i] = 0; end
        if (hit(m_qk[i])) begin nvk[i] = bus.cdb_data; nqk[i] = 0; end
        if (nqj[i] == 0 && nqk[i] == 0) nst[i] = M_READY;
      end
      if (m_st[i] == M_DISP && m_ev && bus.exec_ready) nst[i] = M_EXEC;
      if (m_st[i] == M_EXEC && hit(4'(TAG_BASE + i))) begin
        nst[i] = M_FREE;
        for (int k = 0; k < order.size(); k++)
          if (order[k] == i) begin order.delete(k); break; end
      end
    end
    if (!m_ev || bus.exec_ready) begin
      sel  = model_pick();
      m_ev = (sel >= 0);
      if (sel >= 0) begin
        nst[sel] = M_DISP;
        m_eop = m_op[sel]; m_ea = m_vj[sel]; m_eb = m_vk[sel];
        m_etag = 4'(TAG_BASE + sel);
      end
    end
    if (bus.en && fi >= 0) begin
      m_op[fi] = bus.ALUop;
      nvj[fi] = hit(bus.qj) ? bus.cdb_data : bus.vj;
      nqj[fi] = hit(bus.qj) ? 4'd0 : bus.qj;
      nvk[fi] = hit(bus.qk) ? bus.cdb_data : bus.vk;
      nqk[fi] = hit(bus.qk) ? 4'd0 : bus.qk;
      nst[fi] = (nqj[fi] == 0 && nqk[fi] == 0) ? M_READY : M_WAIT;
      order.push_back(fi);
    end
    m_st = nst; m_vj = nvj; m_vk = nvk; m_qj = nqj; m_qk = nqk;
  endtask

  task automatic compare_all();
    int fi;
    fi = model_free();
    check("isFull", bus.isFull, fi < 0);
    check("issue_tag", bus.issue_tag, (fi < 0) ? 0 : TAG_BASE + fi);
    check("exec_valid", bus.exec_valid, m_ev);
    check("exec_op", bus.exec_op, m_eop);
    check("exec_a", bus.exec_a, m_ea);
    check("exec_b", bus.exec_b, m_eb);
    check("exec_tag", bus.exec_tag, m_etag);
  endtask

  task automatic cyc(input bit r, input bit e, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] qa, input logic [3:0] qb,
                     input bit cv, input logic [3:0] ct, input logic [31:0] cd,
                     input bit er);
    rst = r; bus.en = e; bus.ALUop = op; bus.vj = a; bus.vk = b;
    bus.qj = qa; bus.qk = qb; bus.cdb_valid = cv; bus.cdb_tag = ct;
    bus.cdb_data = cd; bus.exec_ready = er;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int exp_tag;
    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_isFull", bus.isFull, 0);
    check("rst_issue_tag", bus.issue_tag, TAG_BASE);
    check("rst_exec_valid", bus.exec_valid, 0);

    // Ready operands dispatch the cycle after the entry becomes READY
    cyc(0, 1, 1, 5, 7, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("ready_valid", bus.exec_valid, 1);
    check("ready_a", bus.exec_a, 5);
    check("ready_b", bus.exec_b, 7);
    check("ready_tag", bus.exec_tag, 1);

    // CDB wakeup of a waiting Qj
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 32'h99, 3, 2, 0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h10, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("wake_valid", bus.exec_valid, 1);
    check("wake_a", bus.exec_a, 32'h10);

    // Issue-time bypass of Qk
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 4, 32'h77, 0, 3, 1, 3, 9, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("bypass_valid", bus.exec_valid, 1);
    check("bypass_b", bus.exec_b, 9);

    // Full station ignores issue; freed slot visible the next cycle
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 3, 3, 0, 0, 0, 0, 0, 0);
    check("full_set", bus.isFull, 1);
    cyc(0, 1, 3, 4, 4, 0, 0, 0, 0, 0, 0);
    check("full_ignored", bus.isFull, 1);
    check("full_tag0", bus.issue_tag, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    check("freed_isFull", bus.isFull, 0);
    check("freed_issue_tag", bus.issue_tag, 1);

    // Stall with two READY entries, slot 2 issued before slot 1
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 2, 2, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 2, 0, 33, 5, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    cyc(0, 1, 1, 22, 0, 0, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 1, 3, 11, 12, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h55, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("stall_valid", bus.exec_valid, 1);
      check("stall_tag", bus.exec_tag, 1);
      check("stall_a", bus.exec_a, 11);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef RS_AGE_PRIORITY_EN
    exp_tag = 3;
`else
    exp_tag = 2;
`endif
    check("prio_tag", bus.exec_tag, exp_tag);

    // Reset while a dispatch is pending
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    check("rst_mid_valid", bus.exec_valid, 0);
    check("rst_mid_isFull", bus.isFull, 0);
    check("rst_mid_issue_tag", bus.issue_tag, TAG_BASE);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) == 0),
          $urandom_range(0, 1),
          2'($urandom_range(0, 3)),
          $urandom, $urandom,
          $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 5)),
          $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 5)),
          $urandom_range(0, 1),
          4'($urandom_range(0, 5)),
          $urandom,
          ($urandom_range(0, 9) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
